decode_issue_queue: RTL and testbench

- Parametrised instruction buffer between fetch and decode; decouples the two with a DEPTH-entry FIFO of (pc, inst) pairs.
- Holds the head instruction while it has a RAW hazard on a register still awaiting writeback, using a per-register pending-write scoreboard.
- Serialises FENCE.I until all pending writes drain and pulses fencei_o on its issue.
- Sits directly before the decode logic and register file; the writeback port feeds the scoreboard release.

---
 rtl/decode_issue_queue_pkg.sv | 13 +
 rtl/decode_scoreboard.sv | 51 +++++
 rtl/decode_issue_queue.sv | 90 +++++++++
 tb/tb_decode_issue_queue.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/decode_issue_queue_pkg.sv
// decode_issue_queue_pkg: RISC-V opcode constants and field widths shared by the issue queue
package decode_issue_queue_pkg;
  localparam int REG_W = 5;
  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
  localparam logic [2:0] F3_FENCEI   = 3'b001;
endpackage

// File: rtl/decode_scoreboard.sv
// decode_scoreboard: per-register pending-write counters with busy/max lookups and a sticky underflow flag
module decode_scoreboard
  import decode_issue_queue_pkg::*;
#(
  parameter int NREGS  = 32,
  parameter int PEND_W = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  inc_en,
  input  logic [REG_W-1:0]      inc_idx,
  input  logic                  dec_en,
  input  logic [REG_W-1:0]      dec_idx,
  input  logic [2:0][REG_W-1:0] idx,
  output logic [2:0]            busy,
  output logic [2:0]            at_max,
  output logic                  any_busy,
  output logic                  err
);
  logic [PEND_W-1:0] pend [NREGS];
  logic dec_zero;
  // Lookups match indices against tracked registers only, so x0 and out-of-range indices read idle
  always_comb begin
    busy = '0;
    at_max = '0;
    any_busy = 1'b0;
    dec_zero = 1'b0;
    for (int r = 1; r < NREGS; r++) begin
      for (int k = 0; k < 3; k++) begin
        if (idx[k] == REG_W'(r)) begin
          busy[k] = pend[r] != '0;
          at_max[k] = &pend[r];
        end
      end
      any_busy = any_busy | (pend[r] != '0);
      dec_zero = dec_zero | (dec_en && dec_idx == REG_W'(r) && pend[r] == '0);
    end
  end
  // Counters step up on issue and down on commit; a commit to an idle counter only raises err
  always_ff @(posedge clock) begin
    if (reset) begin
      pend <= '{default: '0};
      err <= 1'b0;
    end else begin
      for (int r = 1; r < NREGS; r++)
        pend[r] <= pend[r] + PEND_W'(inc_en && inc_idx == REG_W'(r))
                           - PEND_W'(dec_en && dec_idx == REG_W'(r) && pend[r] != '0);
      err <= err | dec_zero;
    end
  end
endmodule

// File: rtl/decode_issue_queue.sv
// decode_issue_queue: fetch-to-decode FIFO that stalls the head on RAW/WAW-saturation hazards and serialises FENCE.I
module decode_issue_queue
  import decode_issue_queue_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int NREGS  = 32,
  parameter int PEND_W = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid_pre_i,
  output logic              ready_pre_o,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [DATA_W-1:0] inst_i,
  output logic              valid_post_o,
  input  logic              ready_post_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [DATA_W-1:0] inst_o,
  output logic              fencei_o,
  input  logic              wena_i,
  input  logic [REG_W-1:0]  waddr_i,
  input  logic              flush_i,
  output logic              sb_err_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  logic [ADDR_W-1:0] pc_mem [DEPTH];
  logic [DATA_W-1:0] inst_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic empty, enq, issue, uses_rs1, uses_rs2, writes_rd, is_fencei, hazard, any_busy;
  logic [6:0] op;
  logic [2:0] f3;
  logic [REG_W-1:0] rs1, rs2, rd;
  logic [2:0] busy, at_max;
  assign empty = count == '0;
  assign ready_pre_o = count < CNT_W'(DEPTH);
  assign pc_o = empty ? '0 : pc_mem[rd_ptr];
  assign inst_o = empty ? '0 : inst_mem[rd_ptr];
  assign op = inst_o[6:0];
  assign f3 = inst_o[14:12];
  assign rs1 = inst_o[19:15];
  assign rs2 = inst_o[24:20];
  assign rd = inst_o[11:7];
  assign uses_rs1 = !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
  assign uses_rs2 = op == OP_BRANCH || op == OP_STORE || op == OP_OP;
  assign writes_rd = rd != '0 && !(op == OP_BRANCH || op == OP_STORE || op == OP_MISC_MEM ||
                                   (op == OP_SYSTEM && f3 == 3'b000));
  assign is_fencei = op == OP_MISC_MEM && f3 == F3_FENCEI;
  assign hazard = (uses_rs1 && busy[0]) || (uses_rs2 && busy[1]) || (writes_rd && at_max[2]) ||
                  (is_fencei && any_busy);
  assign valid_post_o = !empty && !hazard;
  assign issue = valid_post_o && ready_post_i && !flush_i;
  assign enq = valid_pre_i && ready_pre_o && !flush_i;
  assign fencei_o = issue && is_fencei;
  decode_scoreboard #(.NREGS(NREGS), .PEND_W(PEND_W)) u_sb (
    .clock    (clock),
    .reset    (reset),
    .inc_en   (issue && writes_rd),
    .inc_idx  (rd),
    .dec_en   (wena_i),
    .dec_idx  (waddr_i),
    .idx      ({rd, rs2, rs1}),
    .busy     (busy),
    .at_max   (at_max),
    .any_busy (any_busy),
    .err      (sb_err_o)
  );
  // Pointer and occupancy bookkeeping; flush empties the queue but leaves the scoreboard alone
  always_ff @(posedge clock) begin
    if (reset || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(enq);
      rd_ptr <= rd_ptr + PTR_W'(issue);
      count <= count + CNT_W'(enq) - CNT_W'(issue);
    end
  end
  // Entry storage needs no reset since empty masks the head outputs
  always_ff @(posedge clock) begin
    if (enq) begin
      pc_mem[wr_ptr] <= pc_i;
      inst_mem[wr_ptr] <= inst_i;
    end
  end
endmodule

// File: tb/tb_decode_issue_queue.sv
// tb_decode_issue_queue: directed plus randomized checks against a queue-and-counter reference model
module tb_decode_issue_queue;
  localparam int DEPTH = 4;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic valid_pre_i = 1'b0, ready_post_i = 1'b0, wena_i = 1'b0, flush_i = 1'b0;
  logic [31:0] pc_i = '0, inst_i = '0;
  logic [4:0] waddr_i = '0;
  logic ready_pre_o, valid_post_o, fencei_o, sb_err_o;
  logic [31:0] pc_o, inst_o;
  ent_t model_q[$];
  ent_t exp_q[$];
  int pend[32];
  bit err_m;
  int checks = 0;
  int errors = 0;
  always #5 clock = ~clock;
  decode_issue_queue #(.DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .valid_pre_i  (valid_pre_i),
    .ready_pre_o  (ready_pre_o),
    .pc_i         (pc_i),
    .inst_i       (inst_i),
    .valid_post_o (valid_post_o),
    .ready_post_i (ready_post_i),
    .pc_o         (pc_o),
    .inst_o       (inst_o),
    .fencei_o     (fencei_o),
    .wena_i       (wena_i),
    .waddr_i      (waddr_i),
    .flush_i      (flush_i),
    .sb_err_o     (sb_err_o)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic void decode(input logic [31:0] i, output bit u1, output bit u2, output bit wr,
                                 output bit fi, output int r1, output int r2, output int rd);
    logic [6:0] op;
    logic [2:0] f3;
    op = i[6:0];
    f3 = i[14:12];
    r1 = int'(i[19:15]);
    r2 = int'(i[24:20]);
    rd = int'(i[11:7]);
    u1 = !(op == 7'h37 || op == 7'h17 || op == 7'h6f);
    u2 = op == 7'h63 || op == 7'h23 || op == 7'h33;
    wr = rd != 0 && !(op == 7'h63 || op == 7'h23 || op == 7'h0f || (op == 7'h73 && f3 == 3'd0));
    fi = op == 7'h0f && f3 == 3'd1;
  endfunction
  task automatic model_clear();
    model_q.delete();
    exp_q.delete();
    foreach (pend[r]) pend[r] = 0;
    err_m = 0;
  endtask
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    valid_pre_i = 1'b1;
    ready_post_i = 1'b1;
    wena_i = 1'b1;
    waddr_i = 5'd1;
    flush_i = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    valid_pre_i = 1'b0;
    ready_post_i = 1'b0;
    wena_i = 1'b0;
    flush_i = 1'b0;
    model_clear();
  endtask
  task automatic step(input bit v, input logic [31:0] pc, input logic [31:0] inst, input bit rdy,
                      input bit we, input logic [4:0] wa, input bit fl);
    bit u1, u2, wr, fi, any, ev, er;
    int r1, r2, rd;
    @(negedge clock);
    valid_pre_i = v;
    pc_i = pc;
    inst_i = inst;
    ready_post_i = rdy;
    wena_i = we;
    waddr_i = wa;
    flush_i = fl;
    #1;
    er = model_q.size() < DEPTH;
    ev = 0;
    fi = 0;
    wr = 0;
    rd = 0;
    chk("ready_pre", 32'(ready_pre_o), 32'(er));
    if (model_q.size() != 0) begin
      decode(model_q[0].inst, u1, u2, wr, fi, r1, r2, rd);
      any = 0;
      foreach (pend[r]) if (pend[r] > 0) any = 1;
      ev = !((u1 && pend[r1] > 0) || (u2 && pend[r2] > 0) || (wr && pend[rd] == 3) || (fi && any));
      chk("head_pc", pc_o, model_q[0].pc);
      chk("head_inst", inst_o, model_q[0].inst);
    end else begin
      chk("empty_pc", pc_o, 32'd0);
      chk("empty_inst", inst_o, 32'd0);
    end
    chk("valid_post", 32'(valid_post_o), 32'(ev));
    chk("fencei", 32'(fencei_o), 32'(ev && rdy && !fl && fi));
    chk("sb_err", 32'(sb_err_o), 32'(err_m));
    if (we && wa != 0) begin
      if (pend[wa] == 0) err_m = 1;
      else pend[wa]--;
    end
    if (ev && rdy && !fl) begin
      if (wr) pend[rd]++;
      void'(model_q.pop_front());
    end
    if (fl) begin
      model_q.delete();
      exp_q.delete();
    end else if (v && er) begin
      model_q.push_back('{pc, inst});
      exp_q.push_back('{pc, inst});
    end
  endtask
  initial begin : monitor
    ent_t e;
    forever begin
      @(negedge clock);
      #2;
      if (!reset && valid_post_o && ready_post_i && !flush_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL issue_unexpected: got pc %h with no expected entry", pc_o);
        end else begin
          e = exp_q.pop_front();
          chk("issue_pc", pc_o, e.pc);
          chk("issue_inst", inst_o, e.inst);
        end
      end
    end
  end
  initial begin : stim
    logic [6:0] ops[10] = '{7'h37, 7'h17, 7'h6f, 7'h63, 7'h23, 7'h33, 7'h13, 7'h03, 7'h0f, 7'h73};
    int pq[$];
    do_reset();
    step(1, 32'h80000000, 32'h00500093, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(1, 32'h80000004, 32'h00108133, 1, 0, 0, 0);
    repeat (3) step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1, 5'd1, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    for (int k = 0; k < 5; k++) step(1, 32'h100 + 32'(4 * k), 32'h00000013 | (32'(k) << 20), 0, 0, 0, 0);
    step(1, 32'h110, 32'h00400013, 1, 0, 0, 0);
    step(1, 32'h110, 32'h00400013, 1, 0, 0, 0);
    repeat (5) step(0, 0, 0, 1, 0, 0, 0);
    step(1, 32'h200, 32'h00100213, 0, 0, 0, 0);
    step(1, 32'h204, 32'h00000013, 0, 0, 0, 0);
    step(1, 32'h208, 32'h00000013, 0, 0, 0, 0);
    step(1, 32'h20c, 32'h00000013, 1, 1, 5'd2, 1);
    step(1, 32'h300, 32'h000202b3, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(1, 32'h304, 32'h0000100f, 1, 0, 0, 0);
    repeat (2) step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1, 5'd5, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 5'd7, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 5'd0, 0);
    step(1, 32'h400, 32'h00100193, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(1, 32'h404, 32'h00100193, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1, 5'd3, 0);
    step(1, 32'h408, 32'h00018233, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1, 5'd3, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      logic [6:0] op;
      logic [2:0] f3;
      logic [31:0] inst;
      bit we;
      logic [4:0] wa;
      if (c == 700) do_reset();
      op = ops[$urandom_range(0, 9)];
      f3 = 3'($urandom_range(0, 7));
      if (op == 7'h0f) f3 = 3'($urandom_range(0, 1));
      inst = {7'd0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), f3, 5'($urandom_range(0, 7)), op};
      pq.delete();
      foreach (pend[r]) if (pend[r] > 0) pq.push_back(r);
      we = 0;
      wa = '0;
      if (pq.size() != 0 && $urandom_range(0, 2) == 0) begin
        we = 1;
        wa = 5'(pq[$urandom_range(0, pq.size() - 1)]);
      end else if ($urandom_range(0, 59) == 0) begin
        we = 1;
        wa = 5'($urandom_range(0, 31));
      end
      step($urandom_range(0, 9) < 7, 32'($urandom), inst, $urandom_range(0, 9) < 7, we, wa,
           $urandom_range(0, 39) == 0);
    end
    step(0, 0, 0, 0, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
